// File: rtl/fifo_pntrs_and_flags_sc.sv
// ---------------------------------------------------------------------------
// fifo_pntrs_and_flags_sc
// Single-clock FIFO with registered pointers, word count and status flags.
//
// Configuration macro:
//   FIFO_SHOWAHEAD_EN : when defined, q_o always presents the head word while
//                       the FIFO is non-empty (show-ahead mode). When
//                       undefined, q_o updates to the popped word one cycle
//                       after an accepted read and holds otherwise.
//
// Ports:
//   clk_i          in   1        clock, rising edge
//   srst_i         in   1        synchronous active-high reset
//   data_i         in   DWIDTH   write data
//   wrreq_i        in   1        write request
//   rdreq_i        in   1        read request
//   q_o            out  DWIDTH   read data
//   empty_o        out  1        usedw_o == 0
//   full_o         out  1        usedw_o == 2**AWIDTH
//   usedw_o        out  AWIDTH+1 stored word count
//   almost_full_o  out  1        usedw_o >= ALMOST_FULL_VALUE
//   almost_empty_o out  1        usedw_o <  ALMOST_EMPTY_VALUE
//   wr_ovf_o       out  1        pulse: previous-cycle write was rejected
//   rd_unf_o       out  1        pulse: previous-cycle read was rejected
// ---------------------------------------------------------------------------
module fifo_pntrs_and_flags_sc #(
    parameter int DWIDTH             = 8,
    parameter int AWIDTH             = 3,
    parameter int ALMOST_FULL_VALUE  = 6,
    parameter int ALMOST_EMPTY_VALUE = 2
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              wr_ovf_o,
    output logic              rd_unf_o
);

    localparam int              UW      = AWIDTH + 1;
    localparam logic [AWIDTH:0] DEPTH_W = UW'(2 ** AWIDTH);
    localparam logic [AWIDTH:0] AF_W    = UW'(ALMOST_FULL_VALUE);
    localparam logic [AWIDTH:0] AE_W    = UW'(ALMOST_EMPTY_VALUE);

    // Storage is deliberately not reset; the pointers make stale words
    // unreachable after a reset.
    logic [DWIDTH-1:0] mem [0:2**AWIDTH-1];

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   usedw_q, usedw_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              af_q, af_d;
    logic              ae_q, ae_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [DWIDTH-1:0] q_q, q_d;
    logic              wr_acc;
    logic              rd_acc;

    always_comb begin
        // Acceptance looks only at the registered flags, so a full FIFO
        // can still take a read and an empty one can still take a write.
        wr_acc = wrreq_i & ~full_q;
        rd_acc = rdreq_i & ~empty_q;

        // Pointers wrap naturally through their AWIDTH-bit width.
        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;

        usedw_d = usedw_q;
        case ({wr_acc, rd_acc})
            2'b10:   usedw_d = usedw_q + 1'b1;
            2'b01:   usedw_d = usedw_q - 1'b1;
            default: usedw_d = usedw_q;
        endcase

        // Flags come from the next count so they move together with usedw_o.
        empty_d = (usedw_d == '0);
        full_d  = (usedw_d == DEPTH_W);
        af_d    = (usedw_d >= AF_W);
        ae_d    = (usedw_d <  AE_W);

        ovf_d = wrreq_i & full_q;
        unf_d = rdreq_i & empty_q;

        q_d = q_q;
`ifdef FIFO_SHOWAHEAD_EN
        // Present the word that will be at the head after this edge. When
        // that slot is being written in this same cycle (write into an empty
        // FIFO, or read+write with one word stored) the memory does not hold
        // it yet, so bypass from data_i.
        if (usedw_d != '0) begin
            if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
                q_d = data_i;
            end else begin
                q_d = mem[rd_ptr_d];
            end
        end
`else
        if (rd_acc) begin
            q_d = mem[rd_ptr_q];
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            q_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            q_q      <= q_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc && !srst_i) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    assign q_o            = q_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign usedw_o        = usedw_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign wr_ovf_o       = ovf_q;
    assign rd_unf_o       = unf_q;

endmodule

// File: doc/fifo_pntrs_and_flags_sc.md
FIFO_PNTRS_AND_FLAGS_SC -- requirements
Module: fifo_pntrs_and_flags_sc

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter AWIDTH, default 3, meaning address width; depth = 2**AWIDTH words.
REQ-003 SHALL have parameter ALMOST_FULL_VALUE, default 6, meaning usedw threshold for almost_full_o; legal range 1..2**AWIDTH.
REQ-004 SHALL have parameter ALMOST_EMPTY_VALUE, default 2, meaning usedw threshold for almost_empty_o; legal range 1..2**AWIDTH.
REQ-005 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port srst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port data_i  input  DWIDTH  write data.
REQ-008 SHALL have port wrreq_i  input  1  write request.
REQ-009 SHALL have port rdreq_i  input  1  read request.
REQ-010 SHALL have port q_o  output  DWIDTH  read data.
REQ-011 SHALL have port empty_o  output  1  FIFO empty.
REQ-012 SHALL have port full_o  output  1  FIFO full.
REQ-013 SHALL have port usedw_o  output  AWIDTH+1  stored word count, 0..2**AWIDTH.
REQ-014 SHALL have port almost_full_o  output  1  usedw_o >= ALMOST_FULL_VALUE.
REQ-015 SHALL have port almost_empty_o  output  1  usedw_o < ALMOST_EMPTY_VALUE.
REQ-016 SHALL have port wr_ovf_o  output  1  one-cycle pulse: write rejected.
REQ-017 SHALL have port rd_unf_o  output  1  one-cycle pulse: read rejected.

Function
REQ-018 SHALL accept a write when wrreq_i=1 and full_o=0; the word is stored at the write pointer, which increments modulo 2**AWIDTH.
REQ-019 SHALL accept a read when rdreq_i=1 and empty_o=0; the read pointer increments modulo 2**AWIDTH.
REQ-020 SHALL gate acceptance on the registered flags only; full_o=1 with both requests: read accepted, write rejected; empty_o=1 with both requests: write accepted, read rejected.
REQ-021 SHALL update usedw_o one cycle after acceptance: +1 write only, -1 read only, unchanged for both or neither.
REQ-022 SHALL register empty_o, full_o, almost_full_o, almost_empty_o from the next usedw value, so all flags change in the same cycle as usedw_o.
REQ-023 SHALL assert full_o exactly when usedw_o = 2**AWIDTH and empty_o exactly when usedw_o = 0.
REQ-024 SHALL pulse wr_ovf_o the cycle after a rejected write and rd_unf_o the cycle after a rejected read; usedw_o, pointers and memory unchanged by rejected requests.
REQ-025 SHALL make a written word readable starting the cycle empty_o deasserts (one-cycle write-to-empty latency).
REQ-026 SHALL keep pointer wrap-around transparent: data order preserved across any number of wraps.
REQ-027 SHALL hold q_o stable in all cycles without an accepted read (normal mode).

Reset
REQ-028 SHALL, on srst_i=1 at a clock edge, set pointers 0, usedw_o 0, empty_o 1, full_o 0, almost_full_o 0, almost_empty_o 1, wr_ovf_o 0, rd_unf_o 0, q_o 0.
REQ-029 SHALL give srst_i priority over wrreq_i/rdreq_i; requests in the reset cycle are discarded with no ovf/unf pulse.
REQ-030 SHALL not reset memory contents; data before reset is unreachable after reset.

Configuration
REQ-031 SHALL support macro FIFO_SHOWAHEAD_EN.
REQ-032 Without FIFO_SHOWAHEAD_EN: normal mode; q_o updates to the read word one cycle after an accepted read.
REQ-033 With FIFO_SHOWAHEAD_EN: q_o SHALL equal the head word in every cycle empty_o=0, including the cycle after a write into an empty FIFO and the cycle after a read (next word presented); q_o is don't-care while empty_o=1.

Verification (DWIDTH=8, AWIDTH=3, AF=6, AE=2)
REQ-034 Fill: 8 writes 0x01..0x08 -> usedw_o 1..8, almost_full_o=1 at usedw 6, full_o=1 at 8; 9th write -> wr_ovf_o pulse, usedw_o stays 8.
REQ-035 Drain: 8 reads after fill -> data 0x01..0x08 in order, empty_o=1 at usedw 0; extra read -> rd_unf_o pulse, usedw_o stays 0.
REQ-036 Simultaneous: usedw_o=4, wrreq_i=rdreq_i=1 for 20 cycles -> usedw_o constant 4, pointers wrap twice, output order matches input.
REQ-037 Boundaries: full with both requests -> usedw_o 7, full_o=0, wr_ovf_o pulse; empty with both -> usedw_o 1, empty_o=0, rd_unf_o pulse.
REQ-038 Reset mid-operation: usedw_o=5, srst_i=1 with wrreq_i=1 -> next cycle usedw_o=0, empty_o=1, almost_empty_o=1, no ovf pulse.
REQ-039 Showahead (FIFO_SHOWAHEAD_EN): write 0xA5 to empty FIFO -> empty_o=0 and q_o=0xA5 same cycle, no rdreq_i needed.
